// File: rtl/ahb_apb_bridge_mp.sv
// ahb_apb_bridge_mp
//   AHB-Lite slave to APB3 master bridge that serves a bank of NUM_SLV APB
//   peripherals. Each AHB transfer is decoded to one slave, and the bridge
//   then runs the APB SETUP/ACCESS sequence. The bridge turns these
//   conditions into the two-cycle AHB ERROR response:
//     - decode misses,
//     - Pslverr,
//     - ACCESS timeouts.
//   A new address phase is accepted in the cycle a transfer completes.
//
// Ports
//   Hclk, Hreset      clock, asynchronous active-high reset
//   Hwrite, Hreadyin, Htrans, Haddr, Hwdata
//                     AHB address/data phase inputs
//   Hrdata, Hresp, Hreadyout
//                     AHB response
//   Prdata, Pready, Pslverr
//                     per-slave APB returns; slave i is at [i*DATA_W +: DATA_W]
//   Paddr, Pwdata, Pselx, Pwrite, Penable
//                     APB master outputs; Pselx is one-hot
module ahb_apb_bridge_mp #(
  parameter int               ADDR_W   = 32,
  parameter int               DATA_W   = 32,
  parameter int               NUM_SLV  = 4,
  parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000,
  parameter int               REGION_W = 12,
  parameter int               TIMEOUT  = 16
) (
  input  logic                        Hclk,
  input  logic                        Hreset,
  input  logic                        Hwrite,
  input  logic                        Hreadyin,
  input  logic [1:0]                  Htrans,
  input  logic [ADDR_W-1:0]           Haddr,
  input  logic [DATA_W-1:0]           Hwdata,
  output logic [DATA_W-1:0]           Hrdata,
  output logic                        Hresp,
  output logic                        Hreadyout,
  input  logic [NUM_SLV*DATA_W-1:0]   Prdata,
  input  logic [NUM_SLV-1:0]          Pready,
  input  logic [NUM_SLV-1:0]          Pslverr,
  output logic [ADDR_W-1:0]           Paddr,
  output logic [DATA_W-1:0]           Pwdata,
  output logic [NUM_SLV-1:0]          Pselx,
  output logic                        Pwrite,
  output logic                        Penable
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The timeout fires on the TIMEOUT-th ACCESS cycle. At that point the
  // counter holds TIMEOUT-1, because it starts at 0 on the first ACCESS
  // cycle.
  localparam logic [CNT_W-1:0]  CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : CNT_W'(0);
  localparam logic [ADDR_W:0]   SPAN     = (ADDR_W + 1)'(NUM_SLV) << REGION_W;

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [IDX_W-1:0]    idx_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic                pwrite_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [DATA_W-1:0]   hrdata_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                accept, hit, timeout_hit;
  logic [IDX_W-1:0]    haddr_idx;
  logic                sel_ready, sel_err;
  logic [DATA_W-1:0]   sel_rdata;

  // Compare one bit wider than the address, so that BASE + span cannot
  // wrap at the top of the address space.
  assign hit = ({1'b0, Haddr} >= {1'b0, BASE}) && ({1'b0, Haddr} < ({1'b0, BASE} + SPAN));

  generate
    if (NUM_SLV > 1) begin : g_idx
      assign haddr_idx = Haddr[REGION_W +: IDX_W];
    end else begin : g_idx_single
      assign haddr_idx = '0;
    end
  endgenerate

  // Hreadyout is 1 in IDLE and DONE, so it is not tested again here.
  assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && Hreadyin && Htrans[1];

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Mux the returns of the addressed slave.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ready = Pready[i];
        sel_err   = Pslverr[i];
        sel_rdata = Prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (!accept)     state_d = S_IDLE;
        else if (!hit)   state_d = S_ERR1;
        else if (Hwrite) state_d = S_WDATA;
        else             state_d = S_SETUP;
      end
      S_WDATA:  state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (sel_ready)        state_d = sel_err ? S_ERR1 : S_DONE;
        else if (timeout_hit) state_d = S_ERR1;
      end
      S_ERR1:   state_d = S_ERR2;
      S_ERR2:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        addr_q  <= Haddr;
        write_q <= Hwrite;
        idx_q   <= haddr_idx;
      end
      if (state_q == S_WDATA) pwdata_q <= Hwdata;
      // The APB address and direction change only on SETUP entry, so they
      // hold between transfers. A read enters SETUP straight from the
      // address phase, before addr_q has been loaded, so it takes the
      // address from the bus.
      if (state_d == S_SETUP) begin
        paddr_q  <= (state_q == S_WDATA) ? addr_q  : Haddr;
        pwrite_q <= (state_q == S_WDATA) ? write_q : Hwrite;
        cnt_q    <= '0;
      end else if (state_q == S_ACCESS) begin
        cnt_q    <= cnt_q + 1'b1;
      end
      if (state_q == S_ACCESS && sel_ready && !sel_err && !write_q)
        hrdata_q <= sel_rdata;
      else if (state_d == S_ERR1)
        hrdata_q <= '0;
    end
  end

  // Output logic. All of it is decoded from registered state.
  always_comb begin
    Hreadyout = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
    Hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
    Hrdata    = hrdata_q;
    Penable   = (state_q == S_ACCESS);
    Paddr     = paddr_q;
    Pwrite    = pwrite_q;
    Pwdata    = pwdata_q;
    Pselx     = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if ((state_q == S_SETUP || state_q == S_ACCESS) && idx_q == IDX_W'(i))
        Pselx[i] = 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_mp.sv
module tb_ahb_apb_bridge_mp;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic         Hclk = 1'b0;
  logic         Hreset, Hwrite, Hreadyin;
  logic [1:0]   Htrans;
  logic [31:0]  Haddr, Hwdata, Hrdata, Paddr, Pwdata;
  logic         Hresp, Hreadyout, Pwrite, Penable;
  logic [127:0] Prdata;
  logic [3:0]   Pready, Pslverr, Pselx;

  int total = 0;
  int bad   = 0;

  ahb_apb_bridge_mp dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Hrdata(Hrdata),
    .Hresp(Hresp), .Hreadyout(Hreadyout), .Prdata(Prdata), .Pready(Pready),
    .Pslverr(Pslverr), .Paddr(Paddr), .Pwdata(Pwdata), .Pselx(Pselx),
    .Pwrite(Pwrite), .Penable(Penable)
  );

  always #5 Hclk = ~Hclk;

  // APB slave model. The selected slave answers once it has spent wait_cfg
  // ACCESS cycles with Penable high.
  int   acc_cnt;
  int   wait_cfg = 0;
  logic err_cfg  = 1'b0;
  logic ready_now;

  always @(posedge Hclk or posedge Hreset) begin
    if (Hreset)       acc_cnt <= 0;
    else if (Penable) acc_cnt <= acc_cnt + 1;
    else              acc_cnt <= 0;
  end

  always_comb begin
    ready_now = Penable && (acc_cnt >= wait_cfg);
    Pready    = ready_now ? Pselx : 4'b0000;
    Pslverr   = (ready_now && err_cfg) ? Pselx : 4'b0000;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one AHB transfer from an idle bus and samples each cycle on the
  // falling edge. Cycle 1 is the cycle after the address phase.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output int cyc, output logic resp, output logic prev_resp,
                      output logic [31:0] rd, output int pen, output int setup,
                      output logic [3:0] psel, output logic [3:0] psel_end);
    Haddr = addr; Hwrite = wr; Htrans = 2'b10; Hreadyin = 1'b1;
    @(posedge Hclk); #1;
    Htrans = 2'b00; Hwdata = wd;
    cyc = 0; resp = 0; prev_resp = 0; rd = 0; pen = 0; setup = 0; psel = 0; psel_end = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge Hclk);
      if (Hreadyout) begin
        cyc = c; resp = Hresp; rd = Hrdata; psel_end = Pselx;
        break;
      end
      prev_resp = Hresp;
      psel |= Pselx;
      if (Penable) pen++;
      else if (Pselx != 4'b0) setup++;
    end
    if (cyc == 0) $display("FAIL xfer %h: no Hreadyout within 100 cycles", addr);
    @(posedge Hclk); #1;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    int          waits;
    logic        err;
    int          exp_cyc;
    logic        exp_resp;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_pen;
    logic [3:0]  exp_psel;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int cyc, pen, setup;
  logic resp, prev_resp, ok;
  logic [31:0] rd, last_paddr;
  logic [3:0] psel, psel_end;

  initial begin
    //              wr    addr          wd            wait err cyc resp chk rd            pen psel
    vecs[0] = '{1'b0, 32'h8000_1004, 32'h0,         0,    1'b0, 3,  1'b0, 1'b1, 32'hCAFE_0001, 1,  4'b0010};
    vecs[1] = '{1'b1, 32'h8000_3010, 32'hA5A5_5A5A, 2,    1'b0, 6,  1'b0, 1'b0, 32'h0,         3,  4'b1000};
    vecs[2] = '{1'b0, 32'h8000_4000, 32'h0,         0,    1'b0, 2,  1'b1, 1'b1, 32'h0,         0,  4'b0000};
    vecs[3] = '{1'b1, 32'h8000_2008, 32'h1111_2222, 0,    1'b1, 5,  1'b1, 1'b1, 32'h0,         1,  4'b0100};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'h0,         1,    1'b0, 4,  1'b0, 1'b1, 32'hCAFE_0000, 2,  4'b0001};
    vecs[5] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         0,    1'b0, 2,  1'b1, 1'b1, 32'h0,         0,  4'b0000};
    vecs[6] = '{1'b0, 32'h8000_3FFC, 32'h0,         0,    1'b0, 3,  1'b0, 1'b1, 32'hCAFE_0003, 1,  4'b1000};
    vecs[7] = '{1'b0, 32'h8000_1000, 32'h0,         0,    1'b1, 4,  1'b1, 1'b1, 32'h0,         1,  4'b0010};
    vecs[8] = '{1'b1, 32'h8000_0FF0, 32'h1234_5678, 0,    1'b0, 4,  1'b0, 1'b0, 32'h0,         1,  4'b0001};
    vecs[9] = '{1'b0, 32'h8000_2000, 32'h0,         1000, 1'b0, 19, 1'b1, 1'b1, 32'h0,         16, 4'b0100};

    for (int i = 0; i < 4; i++) Prdata[i*32 +: 32] = 32'hCAFE_0000 + i;
    Hreset = 1'b0; Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = 2'b00; Haddr = '0; Hwdata = '0;

    // Reset values, checked before any clock edge.
    #1 Hreset = 1'b1;
    #2;
    check("reset ctrl", {Hreadyout, Hresp, Pselx, Pwrite, Penable}, {1'b1, 1'b0, 4'b0, 1'b0, 1'b0});
    check("reset Hrdata", Hrdata, 32'h0);
    check("reset Paddr", Paddr, 32'h0);
    check("reset Pwdata", Pwdata, 32'h0);
    @(posedge Hclk); #1 Hreset = 1'b0;
    @(posedge Hclk); #1;

    // Transfers the bridge must ignore: a hit address with Hreadyin low,
    // and BUSY.
    for (int k = 0; k < 2; k++) begin
      Haddr = BASE + 32'h1000; Hwrite = 1'b0;
      Hreadyin = (k == 0) ? 1'b0 : 1'b1;
      Htrans   = (k == 0) ? 2'b10 : 2'b01;
      @(negedge Hclk);
      check($sformatf("ignore%0d during", k), {Hreadyout, Hresp}, 2'b10);
      @(posedge Hclk); #1;
      Htrans = 2'b00; Hreadyin = 1'b1;
      @(negedge Hclk);
      check($sformatf("ignore%0d after", k), {Hreadyout, Hresp, Penable, Pselx}, {1'b1, 1'b0, 1'b0, 4'b0});
      @(posedge Hclk); #1;
    end

    // Table-driven transfers
    last_paddr = 32'h0;
    for (int i = 0; i < NV; i++) begin
      wait_cfg = vecs[i].waits; err_cfg = vecs[i].err;
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wd, cyc, resp, prev_resp, rd, pen, setup, psel, psel_end);
      check($sformatf("v%0d done cycle", i), cyc, vecs[i].exp_cyc);
      check($sformatf("v%0d Hresp", i), resp, vecs[i].exp_resp);
      check($sformatf("v%0d Hresp prev cycle", i), prev_resp, vecs[i].exp_resp);
      if (vecs[i].chk_rd) check($sformatf("v%0d Hrdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d Penable cycles", i), pen, vecs[i].exp_pen);
      check($sformatf("v%0d Pselx seen", i), psel, vecs[i].exp_psel);
      check($sformatf("v%0d Pselx at end", i), psel_end, 4'b0);
      if (vecs[i].exp_psel != 4'b0) begin
        check($sformatf("v%0d setup cycles", i), setup, 1);
        check($sformatf("v%0d Paddr", i), Paddr, vecs[i].addr);
        check($sformatf("v%0d Pwrite", i), Pwrite, vecs[i].wr);
        if (vecs[i].wr) check($sformatf("v%0d Pwdata", i), Pwdata, vecs[i].wd);
        last_paddr = vecs[i].addr;
      end else begin
        check($sformatf("v%0d Paddr held", i), Paddr, last_paddr);
      end
    end

    // Back-to-back reads. The second address phase is presented in DONE.
    wait_cfg = 0; err_cfg = 1'b0;
    Haddr = BASE; Hwrite = 1'b0; Htrans = 2'b10;
    @(posedge Hclk); #1 Htrans = 2'b00;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Hclk);
      if (Hreadyout) begin ok = 1'b1; break; end
    end
    check("b2b first done", ok, 1'b1);
    check("b2b first data", Hrdata, 32'hCAFE_0000);
    Haddr = BASE + 32'h3000; Htrans = 2'b10;
    @(posedge Hclk); #1 Htrans = 2'b00;
    @(negedge Hclk);
    check("b2b second setup", {Hreadyout, Penable, Pselx}, {1'b0, 1'b0, 4'b1000});
    @(negedge Hclk);
    check("b2b second access", {Hreadyout, Penable, Pselx}, {1'b0, 1'b1, 4'b1000});
    @(negedge Hclk);
    check("b2b second done", {Hreadyout, Hresp}, 2'b10);
    check("b2b second data", Hrdata, 32'hCAFE_0003);
    @(posedge Hclk); #1;

    // Reset pulse during ACCESS, then a normal transfer.
    wait_cfg = 1000;
    Haddr = BASE + 32'h1000; Hwrite = 1'b0; Htrans = 2'b10;
    @(posedge Hclk); #1 Htrans = 2'b00;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Hclk);
      if (Penable) begin ok = 1'b1; break; end
    end
    check("rst reached access", ok, 1'b1);
    #1 Hreset = 1'b1;
    #1;
    check("rst mid ctrl", {Hreadyout, Hresp, Pselx, Pwrite, Penable}, {1'b1, 1'b0, 4'b0, 1'b0, 1'b0});
    check("rst mid Paddr", Paddr, 32'h0);
    check("rst mid Hrdata", Hrdata, 32'h0);
    @(posedge Hclk); #1 Hreset = 1'b0;
    wait_cfg = 0;
    @(posedge Hclk); #1;
    xfer(1'b0, BASE + 32'h2004, 32'h0, cyc, resp, prev_resp, rd, pen, setup, psel, psel_end);
    check("post-rst done cycle", cyc, 3);
    check("post-rst Hresp", resp, 1'b0);
    check("post-rst Hrdata", rd, 32'hCAFE_0002);
    check("post-rst Pselx", psel, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
